// File: rtl/addsub_byte_seq.sv
// addsub_byte_seq: multi-cycle WIDTH-bit add/subtract sequencer.
// An 8-bit add/sub slice walks the operand bytes LSB first.
// The raw carry is chained from one byte to the next.
// The flags OF/SF/CF/ZF follow the 8-bit adder stage:
//   subtract = x + ~y + 1, CF = raw carry-out ^ sub.
// Handshakes: an input transfer happens on a rising edge where
// in_valid && in_ready. An output transfer happens on a rising edge where
// out_valid && out_ready. The producer and consumer hold their data until
// that transfer.
// Optional feature macro: ADDSEQ_CMP_EN adds the registered outputs lt/ltu
// (the signed and unsigned x < y results when sub = 1).
// WIDTH must be a multiple of 8 and at least 8.
module addsub_byte_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             OF,
  output logic             SF,
  output logic             CF,
`ifdef ADDSEQ_CMP_EN
  output logic             lt,
  output logic             ltu,
`endif
  output logic             ZF
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] ym_q, ym_d;      // y, or ~y when subtracting
  logic [WIDTH-1:0] f_q, f_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;  // every byte so far summed to zero
  logic             of_q, of_d;
  logic             sf_q, sf_d;
  logic             cf_q, cf_d;
  logic             zf_q, zf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef ADDSEQ_CMP_EN
  logic             lt_q, lt_d;
  logic             ltu_q, ltu_d;
`endif

  // Byte slice: the current operand bytes, their 9-bit sum, and the
  // last-byte indicator.
  logic [7:0] xb, ymb, sb;
  logic       cout;
  logic       last;
  logic       of_calc;

  // Select the current byte pair and add it with the chained carry.
  always_comb begin
    xb          = 8'(x_q >> {idx_q, 3'b000});
    ymb         = 8'(ym_q >> {idx_q, 3'b000});
    {cout, sb}  = {1'b0, xb} + {1'b0, ymb} + {8'd0, carry_q};
    last        = (idx_q == IDXW'(NBYTES - 1));
    // Overflow uses the (possibly inverted) y MSB that was really added.
    of_calc     = (~xb[7] & ~ymb[7] & sb[7]) | (xb[7] & ymb[7] & ~sb[7]);
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    ym_d        = ym_q;
    f_d         = f_q;
    idx_d       = idx_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    zacc_d      = zacc_q;
    of_d        = of_q;
    sf_d        = sf_q;
    cf_d        = cf_q;
    zf_d        = zf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef ADDSEQ_CMP_EN
    lt_d        = lt_q;
    ltu_d       = ltu_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d        = x;
          ym_d       = sub ? ~y : y;
          sub_d      = sub;
          carry_d    = sub;          // the +1 of two's-complement subtract
          idx_d      = '0;
          zacc_d     = 1'b1;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NBYTES; k++) begin
          if (idx_q == IDXW'(k)) f_d[k*8 +: 8] = sb;
        end
        carry_d = cout;
        zacc_d  = zacc_q & (sb == 8'd0);
        idx_d   = idx_q + IDXW'(1);
        if (last) begin
          of_d        = of_calc;
          sf_d        = sb[7];
          cf_d        = cout ^ sub_q;
          zf_d        = zacc_q & (sb == 8'd0);
`ifdef ADDSEQ_CMP_EN
          lt_d        = sb[7] ^ of_calc;
          ltu_d       = cout ^ sub_q;
`endif
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Hold everything until the consumer takes the result.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; a synchronous reset discards any
  // operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      ym_q        <= '0;
      f_q         <= '0;
      idx_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b0;
      of_q        <= 1'b0;
      sf_q        <= 1'b0;
      cf_q        <= 1'b0;
      zf_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ADDSEQ_CMP_EN
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      ym_q        <= ym_d;
      f_q         <= f_d;
      idx_q       <= idx_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      zacc_q      <= zacc_d;
      of_q        <= of_d;
      sf_q        <= sf_d;
      cf_q        <= cf_d;
      zf_q        <= zf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ADDSEQ_CMP_EN
      lt_q        <= lt_d;
      ltu_q       <= ltu_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign OF        = of_q;
  assign SF        = sf_q;
  assign CF        = cf_q;
  assign ZF        = zf_q;
`ifdef ADDSEQ_CMP_EN
  assign lt        = lt_q;
  assign ltu       = ltu_q;
`endif

endmodule

// File: tb/tb_addsub_byte_seq.sv
// Testbench for addsub_byte_seq (WIDTH = 32).
// The expected results come from an arithmetic model.
// They are pushed when an operation is accepted and popped when out_valid rises.
module tb_addsub_byte_seq;

  localparam int W  = 32;
  localparam int NB = W / 8;

  // Clock and reset.
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         OF, SF, CF, ZF;
`ifdef ADDSEQ_CMP_EN
  logic         lt, ltu;
`endif

  always #5 clk = ~clk;

  addsub_byte_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .OF        (OF),
    .SF        (SF),
    .CF        (CF),
`ifdef ADDSEQ_CMP_EN
    .lt        (lt),
    .ltu       (ltu),
`endif
    .ZF        (ZF)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard entry layout: {f, OF, SF, CF, ZF}.
  logic [W+3:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic with textbook overflow and carry rules.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    logic [W:0]   r;
    logic [W-1:0] res;
    logic         o, c;
    if (!s) begin
      r   = {1'b0, a} + {1'b0, b};
      res = r[W-1:0];
      c   = r[W];
      o   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
    end else begin
      res = a - b;
      c   = (a < b);
      o   = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
    end
    return {res, o, res[W-1], c, (res == '0)};
  endfunction

  // Driver: wait for in_ready, present one operation and record its expectation.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    x        = a;
    y        = b;
    sub      = s;
    @(posedge clk);
    exp_q.push_back(model(a, b, s));
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: measure latency from the accept edge and compare against the
  // scoreboard. Then optionally stall for 'hold' cycles and finish the handshake.
  task automatic recv(input int hold, input bit scramble);
    int           k;
    logic [W+3:0] e;
    out_ready = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);   // the negedge following accept edge E+k
      if (scramble) begin
        x   = $urandom;
        y   = $urandom;
        sub = 1'($urandom_range(0, 1));
      end
      if (out_valid) break;
    end
    chk("latency", k, NB);
    if (exp_q.size() == 0) begin
      chk("exp_queue_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk("f",  f,  e[W+3:4]);
    chk("OF", OF, e[3]);
    chk("SF", SF, e[2]);
    chk("CF", CF, e[1]);
    chk("ZF", ZF, e[0]);
`ifdef ADDSEQ_CMP_EN
    chk("lt",  lt,  e[2] ^ e[3]);
    chk("ltu", ltu, e[1]);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      x   = $urandom;
      y   = $urandom;
      sub = 1'($urandom_range(0, 1));
      chk("hold", {out_valid, in_ready, f, OF, SF, CF, ZF}, {2'b10, e});
    end
    if (k >= 20) return;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_ack_ready_valid", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    int vcount;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    sub       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {in_ready, out_valid, f, OF, SF, CF, ZF}, {2'b10, 36'd0});

    send(32'h0000_00FF, 32'h0000_0001, 1'b0); recv(0, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); recv(0, 1'b0);
    send(32'h0000_0005, 32'h0000_0005, 1'b1); recv(0, 1'b0);
    send(32'h0000_0000, 32'h0000_0001, 1'b1); recv(0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); recv(10, 1'b0);

    // Reset during the second RUN cycle discards the operation.
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_reset_state", {in_ready, out_valid, f, OF, SF, CF, ZF}, {2'b10, 36'd0});
    vcount = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    out_ready = 1'b0;
    chk("no_valid_after_reset", vcount, 0);
    send(32'h0000_0001, 32'h0000_0002, 1'b0); recv(0, 1'b0);

    // Operand changes during RUN are ignored.
    send(32'h8000_0000, 32'h0000_0001, 1'b1); recv(0, 1'b1);

    // Random operations, with a random short stall before each result is taken.
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
      recv($urandom_range(0, 3), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
